// File: rtl/vector_packer_1x32b_to_128x32b_pkg.sv
// Shared constants, FSM encoding and slot-offset helper for the 128x32b vector packer.
package vector_packer_1x32b_to_128x32b_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 128;
  localparam int IDX_W     = 7;
  localparam int VEC_W     = WORD_W * NUM_WORDS;
  localparam int CNT_W     = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  function automatic int unsigned slot_offset(input int unsigned idx);
    return idx * WORD_W;
  endfunction

endpackage

// File: rtl/vector_packer_1x32b_to_128x32b_decoder.sv
// One-hot slot write-enable decoder; the inverse of the 128-way word selector mux.
module decoder_7b_to_128b_onehot
  import vector_packer_1x32b_to_128x32b_pkg::*;
(
  input  logic [IDX_W-1:0]     i_idx,
  input  logic                 i_en,
  output logic [NUM_WORDS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vector_packer_1x32b_to_128x32b.sv
// Packs a stream of 32b words into a 4096b vector and hands it downstream over valid/ready.
// Optional macro PACKER_ADDR_WRITE_EN: words are scattered to slot in_select instead of filled in order.
module vector_packer_1x32b_to_128x32b
  import vector_packer_1x32b_to_128x32b_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_last,
`ifdef PACKER_ADDR_WRITE_EN
  input  logic [IDX_W-1:0]     in_select,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VEC_W-1:0]     out_data,
  output logic [NUM_WORDS-1:0] out_mask,
  output logic [CNT_W-1:0]     out_count
);

  packer_state_e          r_state;
  packer_state_e          w_nextState;
  logic [VEC_W-1:0]       r_data;
  logic [NUM_WORDS-1:0]   r_mask;
  logic [CNT_W-1:0]       r_count;
  logic [NUM_WORDS-1:0]   w_we;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_accept;
  logic                   w_release;
  logic                   w_done;
  logic                   w_newSlot;

  assign in_ready  = (r_state == FILL) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_release = (r_state == HOLD) && out_ready;

`ifdef PACKER_ADDR_WRITE_EN
  // Rewrites of an already-marked slot replace the data but do not count again.
  assign w_idx     = in_select;
  assign w_newSlot = ~r_mask[w_idx];
  assign w_done    = in_last || (&(r_mask | w_we));
`else
  logic [IDX_W-1:0] r_wrPtr;

  assign w_idx     = r_wrPtr;
  assign w_newSlot = 1'b1;
  assign w_done    = in_last || (r_wrPtr == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_wrPtr <= '0;
    end else if (w_accept && !w_done) begin
      r_wrPtr <= r_wrPtr + IDX_W'(1);
    end
  end
`endif

  decoder_7b_to_128b_onehot u_decoder (
    .i_idx    (w_idx),
    .i_en     (w_accept),
    .o_onehot (w_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_accept && w_done) w_nextState = HOLD;
      HOLD:    if (out_ready)          w_nextState = FILL;
      default:                         w_nextState = FILL;
    endcase
  end

  // Releasing the vector clears the buffer so unwritten slots of the next vector read 0.
  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_data  <= '0;
      r_mask  <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_we[i]) begin
          r_data[slot_offset(i) +: WORD_W] <= in_data;
        end
      end
      r_mask  <= r_mask | w_we;
      r_count <= r_count + CNT_W'(w_newSlot);
    end
  end

  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_mask  = r_mask;
  assign out_count = r_count;

endmodule

// File: tb/tb_vector_packer_1x32b_to_128x32b.sv
// Scoreboard bench for the vector packer: driver feeds a slot-level model, monitor checks every cycle.
module tb_vector_packer_1x32b_to_128x32b;
  import vector_packer_1x32b_to_128x32b_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [4095:0] out_data;
  logic [127:0]  out_mask;
  logic [7:0]    out_count;
`ifdef PACKER_ADDR_WRITE_EN
  logic [6:0]    in_select;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4095:0] data;
    logic [127:0]  mask;
    logic [7:0]    count;
  } vec_t;

  vec_t        expQ[$];
  logic [31:0] mSlot[128];
  bit          mWritten[128];
  int          mCount;
  bit          expHold;
  bit          randomMode;

  vector_packer_1x32b_to_128x32b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef PACKER_ADDR_WRITE_EN
    .in_select (in_select),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkData(input string name, input logic [4095:0] act, input logic [4095:0] exp);
    int bad;
    checks++;
    if (act !== exp) begin
      errors++;
      bad = 0;
      for (int i = 127; i >= 0; i--) begin
        if (act[i*32 +: 32] !== exp[i*32 +: 32]) bad = i;
      end
      $display("[TB] FAIL %s: slot %0d got %0h expected %0h at %0t",
               name, bad, act[bad*32 +: 32], exp[bad*32 +: 32], $time);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 128; i++) begin
      mSlot[i]    = '0;
      mWritten[i] = 1'b0;
    end
    mCount = 0;
  endtask

  // One clock of stimulus; the model decides acceptance from its own view of readiness.
  task automatic cycle(input bit v, input logic [31:0] d, input bit l, input logic [6:0] sel,
                       input bit ordy, output bit accepted);
    bit   expReady;
    bit   doRelease;
    bit   doPush;
    int   slot;
    vec_t nv;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
`ifdef PACKER_ADDR_WRITE_EN
    in_select = sel;
`endif
    #1;
    expReady = !expHold && !rst;
    checkOutput("in_ready", 128'(in_ready), 128'(expReady));
    accepted  = v && expReady;
    doRelease = expHold && ordy && !rst;
    doPush    = 1'b0;
    if (accepted) begin
`ifdef PACKER_ADDR_WRITE_EN
      slot = int'(sel);
`else
      slot = mCount;
`endif
      if (!mWritten[slot]) mCount++;
      mWritten[slot] = 1'b1;
      mSlot[slot]    = d;
      if (l || mCount == 128) begin
        doPush = 1'b1;
        for (int i = 0; i < 128; i++) begin
          nv.data[i*32 +: 32] = mSlot[i];
          nv.mask[i]          = mWritten[i];
        end
        nv.count = 8'(mCount);
      end
    end
    @(posedge clk);
    if (rst) begin
      expQ.delete();
      expHold = 1'b0;
      modelClear();
    end else begin
      if (doRelease) expHold = 1'b0;
      if (doPush) begin
        expQ.push_back(nv);
        expHold = 1'b1;
        modelClear();
      end
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    bit acc;
    repeat (n) cycle(1'b0, 32'h0, 1'b0, 7'd0, ordy, acc);
  endtask

  task automatic applyStimulus(input logic [31:0] d, input bit l, input int sel);
    bit acc;
    bit ordy;
    int tries;
    tries = 0;
    if (randomMode && $urandom_range(0, 3) == 0) idle(1, 1'($urandom_range(0, 1)));
    do begin
      ordy = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(1'b1, d, l, 7'(sel), ordy, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: word %0h not accepted after %0d cycles", d, tries);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expHold || expQ.size() > 0) && t < 50) begin
      idle(1, 1'b1);
      t++;
    end
    checkOutput("drain", 128'(expHold || expQ.size() > 0), 128'(0));
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    idle(n, 1'b0);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_out_mask", out_mask, 128'(0));
    checkOutput("reset_out_count", 128'(out_count), 128'(0));
    checkData("reset_out_data", out_data, '0);
  endtask

  task automatic streamWords(input logic [31:0] base, input int n, input bit lastOnEnd);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + 32'(i), lastOnEnd && (i == n - 1), i);
    end
  endtask

  // Monitor: out_valid must track the queue, and a held vector must match the head every cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      checkOutput("out_valid", 128'(out_valid), 128'(expQ.size() > 0));
      if (out_valid && expQ.size() > 0) begin
        checkOutput("out_mask", out_mask, expQ[0].mask);
        checkOutput("out_count", 128'(out_count), 128'(expQ[0].count));
        checkData("out_data", out_data, expQ[0].data);
        if (out_ready && !rst) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
`ifdef PACKER_ADDR_WRITE_EN
    in_select  = '0;
`endif
    expHold    = 1'b0;
    randomMode = 1'b0;
    modelClear();

    $display("[TB] reset");
    resetDut(2);

    $display("[TB] full stream of 128 words");
    streamWords(32'hA500_0000, 128, 1'b0);
    drain();

    $display("[TB] early end after 5 words");
    streamWords(32'h0000_0011, 5, 1'b1);
    drain();

    $display("[TB] backpressure in HOLD");
    streamWords(32'h0000_0077, 3, 1'b1);
    begin
      bit acc;
      repeat (10) cycle(1'b1, $urandom, 1'b0, 7'd5, 1'b0, acc);
      cycle(1'b1, 32'hBAD0_0000, 1'b0, 7'd5, 1'b1, acc);
    end
    applyStimulus(32'hDEAD_0001, 1'b1, 0);
    drain();

    $display("[TB] reset mid-fill");
    streamWords(32'h6000_0000, 60, 1'b0);
    resetDut(1);
    streamWords(32'h7700_0000, 128, 1'b0);
    drain();

    $display("[TB] in_last on the 128th word");
    streamWords(32'hC000_0000, 128, 1'b1);
    drain();

`ifdef PACKER_ADDR_WRITE_EN
    $display("[TB] addressed overwrite");
    applyStimulus(32'h0000_00AA, 1'b0, 127);
    applyStimulus(32'h0000_00BB, 1'b0, 0);
    applyStimulus(32'h0000_00CC, 1'b1, 127);
    drain();
`endif

    $display("[TB] randomized vectors");
    randomMode = 1'b1;
    for (int v = 0; v < 8; v++) begin
      int n;
      n = int'($urandom_range(1, 128));
      for (int i = 0; i < n; i++) begin
`ifdef PACKER_ADDR_WRITE_EN
        applyStimulus($urandom, i == n - 1, int'($urandom_range(0, 127)));
`else
        applyStimulus($urandom, i == n - 1, i);
`endif
      end
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)), 1'b0);
    end
    randomMode = 1'b0;
    drain();
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
